// File: rtl/hazard_forward_unit_mc.sv
// rtl/hazard_forward_unit_mc.sv - EX forwarding, ID hazard detection and multiplier scoreboard
module hazard_forward_unit_mc #(
  parameter int REG_ADDR_W = 5,
  parameter int MULT_LAT   = 4,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_IF_ID,
  input  logic [REG_ADDR_W-1:0] rs2_IF_ID,
  input  logic [REG_ADDR_W-1:0] rd_IF_ID,
  input  logic                  uses_rs1_ID,
  input  logic                  uses_rs2_ID,
  input  logic                  reg_write_ID,
  input  logic                  is_mult_ID,
  input  logic [REG_ADDR_W-1:0] rs1_ID_EX,
  input  logic [REG_ADDR_W-1:0] rs2_ID_EX,
  input  logic [REG_ADDR_W-1:0] rd_ID_EX,
  input  logic                  mem_read_ID_EX,
  input  logic                  is_mult_EX,
  input  logic [REG_ADDR_W-1:0] rd_EX_MEM,
  input  logic [REG_ADDR_W-1:0] rd_MEM_WB,
  input  logic                  reg_write_MEM,
  input  logic                  mem_2_reg_MEM,
  input  logic                  reg_write_WB,
  output logic [1:0]            mux_select_a,
  output logic [1:0]            mux_select_b,
  output logic                  stall,
  output logic                  bubble_ID_EX,
  output logic                  mult_busy,
  output logic                  mult_done,
  output logic [REG_ADDR_W-1:0] mult_rd
);

  localparam logic [CNT_W-1:0] CNT_LAT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] mult_rd_q, mult_rd_d;

  // A fresh issue reloads the counter even in the completion cycle, so busy never drops.
  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    mult_rd_d = mult_rd_q;
    if (is_mult_EX) begin
      busy_d    = 1'b1;
      cnt_d     = CNT_LAT;
      mult_rd_d = rd_ID_EX;
    end else if (busy_q) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      mult_rd_q <= '0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      mult_rd_q <= mult_rd_d;
    end
  end

  logic done_raw;
  assign done_raw = busy_q && (cnt_q == CNT_ONE);

  function automatic logic raw_hit(input logic en, input logic [REG_ADDR_W-1:0] x,
                                   input logic iss, input logic [REG_ADDR_W-1:0] iss_rd,
                                   input logic bsy, input logic [REG_ADDR_W-1:0] pend_rd,
                                   input logic not_last);
    logic nz;
    nz = (x != '0);
    return en && nz && ((iss && x == iss_rd) || (bsy && x == pend_rd && not_last));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs, input logic done,
                                         input logic [REG_ADDR_W-1:0] m_rd,
                                         input logic wr_mem, input logic ld_mem,
                                         input logic [REG_ADDR_W-1:0] rd_mem,
                                         input logic wr_wb, input logic [REG_ADDR_W-1:0] rd_wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (done && rs == m_rd)                       sel = 2'b11;
      else if (wr_mem && !ld_mem && rd_mem == rs)   sel = 2'b10;
      else if (wr_wb && rd_wb == rs)                sel = 2'b01;
    end
    return sel;
  endfunction

  logic not_last, mult_stall, struct_stall, load_stall, stall_raw;
  logic [1:0] sel_a, sel_b;

  // At cnt==2 the dependent instruction may advance: it reaches EX exactly as the result appears.
  always_comb begin
    not_last   = (cnt_q != CNT_TWO);
    mult_stall = raw_hit(uses_rs1_ID, rs1_IF_ID, is_mult_EX, rd_ID_EX, busy_q, mult_rd_q, not_last)
               | raw_hit(uses_rs2_ID, rs2_IF_ID, is_mult_EX, rd_ID_EX, busy_q, mult_rd_q, not_last)
               | raw_hit(reg_write_ID, rd_IF_ID, is_mult_EX, rd_ID_EX, busy_q, mult_rd_q, not_last);
    struct_stall = is_mult_ID && (is_mult_EX || (busy_q && cnt_q > CNT_TWO));
    load_stall   = mem_read_ID_EX && (rd_ID_EX != '0) &&
                   ((uses_rs1_ID && rs1_IF_ID == rd_ID_EX) ||
                    (uses_rs2_ID && rs2_IF_ID == rd_ID_EX));
    stall_raw = mult_stall | struct_stall | load_stall;
    sel_a = fwd_sel(rs1_ID_EX, done_raw, mult_rd_q, reg_write_MEM, mem_2_reg_MEM, rd_EX_MEM,
                    reg_write_WB, rd_MEM_WB);
    sel_b = fwd_sel(rs2_ID_EX, done_raw, mult_rd_q, reg_write_MEM, mem_2_reg_MEM, rd_EX_MEM,
                    reg_write_WB, rd_MEM_WB);
  end

  assign mux_select_a = rst ? 2'b00 : sel_a;
  assign mux_select_b = rst ? 2'b00 : sel_b;
  assign stall        = !rst && stall_raw;
  assign bubble_ID_EX = !rst && stall_raw;
  assign mult_busy    = !rst && busy_q;
  assign mult_done    = !rst && done_raw;
  assign mult_rd      = rst ? '0 : mult_rd_q;

endmodule
